// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit.
// Holds the opcode/func values, ALU and next-PC codes, and the FSM state type.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_JMP = 2'b10;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_e;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ORI, OP_LW, OP_SW: op_legal = 1'b1;
            default:                                               op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle controller (master) and the datapath/IR/memory side (slave).
interface mc_ctrl_if #(
    parameter int ALUCTR_W = 3,
    parameter int CNT_W    = 32
);
    logic [5:0]          op;
    logic [5:0]          func;
    logic                zero;
    logic                mem_ready;
    logic                pc_we;
    logic                ir_we;
    logic [1:0]          npcctr;
    logic                memread;
    logic                memwrite;
    logic                iord;
    logic                alusrc;
    logic [ALUCTR_W-1:0] aluctr;
    logic                regwrite;
    logic                regdst;
    logic                memtoreg;
    logic                illegal;
    logic [CNT_W-1:0]    retired;

    modport master (
        input  op, func, zero, mem_ready,
        output pc_we, ir_we, npcctr, memread, memwrite, iord, alusrc, aluctr,
               regwrite, regdst, memtoreg, illegal, retired
    );

    modport slave (
        output op, func, zero, mem_ready,
        input  pc_we, ir_we, npcctr, memread, memwrite, iord, alusrc, aluctr,
               regwrite, regdst, memtoreg, illegal, retired
    );
endinterface

// File: rtl/mc_alu_dec.sv
// Combinational ALU-control decoder: (op, func) -> ALU code, plus whether an R-type func is supported.
module mc_alu_dec
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTR_W = 3
) (
    input  logic [5:0]          op_i,
    input  logic [5:0]          func_i,
    output logic [ALUCTR_W-1:0] aluctr_o,
    output logic                func_ok_o
);

    always_comb begin
        aluctr_o  = ALUCTR_W'(ALU_ADD);
        func_ok_o = 1'b1;
        case (op_i)
            OP_RTYPE: begin
                case (func_i)
                    FN_ADD:  aluctr_o = ALUCTR_W'(ALU_ADD);
                    FN_SUB:  aluctr_o = ALUCTR_W'(ALU_SUB);
                    FN_AND:  aluctr_o = ALUCTR_W'(ALU_AND);
                    FN_OR:   aluctr_o = ALUCTR_W'(ALU_OR);
                    FN_SLT:  aluctr_o = ALUCTR_W'(ALU_SLT);
                    default: func_ok_o = 1'b0;
                endcase
            end
            OP_BEQ:  aluctr_o = ALUCTR_W'(ALU_SUB);
            OP_ORI:  aluctr_o = ALUCTR_W'(ALU_OR);
            default: aluctr_o = ALUCTR_W'(ALU_ADD);
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready,
// flags illegal encodings and counts retired instructions.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTR_W = 3,
    parameter int CNT_W    = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    mc_ctrl_if.master bus
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic [5:0]          op_q, func_q;
    logic [5:0]          dec_op, dec_func;
    logic [ALUCTR_W-1:0] alu_code;
    logic                func_ok;
    logic                retire;

    // DECODE still sees the live IR fields; later states use the latched copies.
    assign dec_op   = (state_q == S_DECODE) ? bus.op   : op_q;
    assign dec_func = (state_q == S_DECODE) ? bus.func : func_q;

    mc_alu_dec #(.ALUCTR_W(ALUCTR_W)) u_alu_dec (
        .op_i      (dec_op),
        .func_i    (dec_func),
        .aluctr_o  (alu_code),
        .func_ok_o (func_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RST;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_DECODE) begin
            op_q   <= bus.op;
            func_q <= bus.func;
        end
    end

    assign retired_d   = retired_q + CNT_W'(retire);
    assign bus.retired = retired_q;

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        bus.pc_we    = 1'b0;
        bus.ir_we    = 1'b0;
        bus.npcctr   = NPC_SEQ;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.iord     = 1'b0;
        bus.alusrc   = 1'b0;
        bus.aluctr   = '0;
        bus.regwrite = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.illegal  = 1'b0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                bus.memread = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_we = 1'b1;
                    bus.pc_we = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!op_legal(dec_op) || (dec_op == OP_RTYPE && !func_ok)) begin
                    bus.illegal = 1'b1;
                    state_d     = S_FETCH;
                end else if (dec_op == OP_J) begin
                    bus.pc_we  = 1'b1;
                    bus.npcctr = NPC_JMP;
                    retire     = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                bus.aluctr = alu_code;
                bus.alusrc = !(op_q == OP_RTYPE || op_q == OP_BEQ);
                if (op_q == OP_BEQ) begin
                    bus.pc_we  = bus.zero;
                    bus.npcctr = NPC_BR;
                    retire     = 1'b1;
                    state_d    = S_FETCH;
                end else if (op_q == OP_LW || op_q == OP_SW) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                bus.iord     = 1'b1;
                bus.memread  = (op_q == OP_LW);
                bus.memwrite = (op_q == OP_SW);
                if (bus.mem_ready) begin
                    if (op_q == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                bus.regwrite = 1'b1;
                bus.regdst   = (op_q == OP_RTYPE);
                bus.memtoreg = (op_q == OP_LW);
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            default: state_d = S_RST;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle vector table plus async-reset and counter-wrap sequences.
module tb_mc_ctrl;

    localparam logic [5:0] OPR = 6'b000000, OJ = 6'b000010, OBEQ = 6'b000100;
    localparam logic [5:0] OADDI = 6'b001000, OORI = 6'b001101, OLW = 6'b100011;
    localparam logic [5:0] OSW = 6'b101011, OBAD = 6'b111111;
    localparam logic [5:0] FADD = 6'b100000, FSUB = 6'b100010, FAND = 6'b100100;
    localparam logic [5:0] FOR = 6'b100101, FSLT = 6'b101010, FBAD = 6'b000111;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  func;
        logic        zero;
        logic        rdy;
        logic [14:0] ctl;
        logic [31:0] ret;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];

    mc_ctrl_if #(.ALUCTR_W(3), .CNT_W(32)) bus ();
    mc_ctrl_if #(.ALUCTR_W(3), .CNT_W(4))  bus4 ();

    mc_ctrl #(.ALUCTR_W(3), .CNT_W(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    mc_ctrl #(.ALUCTR_W(3), .CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    assign bus4.op        = bus.op;
    assign bus4.func      = bus.func;
    assign bus4.zero      = bus.zero;
    assign bus4.mem_ready = bus.mem_ready;

    always #5 clk = ~clk;

    // {pc_we, ir_we, npcctr[1:0], memread, memwrite, iord, alusrc, aluctr[2:0], regwrite, regdst, memtoreg, illegal}
    logic [14:0] act;
    assign act = {bus.pc_we, bus.ir_we, bus.npcctr, bus.memread, bus.memwrite, bus.iord,
                  bus.alusrc, bus.aluctr, bus.regwrite, bus.regdst, bus.memtoreg, bus.illegal};

    function automatic logic [14:0] c(input logic pc, ir, input logic [1:0] npc,
                                      input logic mr, mw, io, as, input logic [2:0] alu,
                                      input logic rw, rd, mt, il);
        return {pc, ir, npc, mr, mw, io, as, alu, rw, rd, mt, il};
    endfunction

    task automatic v(input logic [5:0] op, func, input logic z, r,
                     input logic [14:0] ctl, input int ret);
        tbl.push_back('{op, func, z, r, ctl, 32'(ret)});
    endtask

    task automatic cyc(input logic [5:0] op, func, input logic z, r);
        @(posedge clk);
        #1;
        bus.op = op; bus.func = func; bus.zero = z; bus.mem_ready = r;
        #1;
    endtask

    task automatic chk_ctl(input string name, input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: ctl got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_ret(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: retired got %0d want %0d", name, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [14:0] F1, F0, Z;
        F1 = c(1, 1, 2'b00, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0);
        F0 = c(0, 0, 2'b00, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0);
        Z  = '0;

        // add; mem_ready/zero toggled outside FETCH/MEM must not matter
        v(OPR, FADD, 0, 1, F1, 0);
        v(OPR, FADD, 0, 0, Z, 0);
        v(OPR, FADD, 1, 0, c(0,0,2'b00,0,0,0,0,3'd0,0,0,0,0), 0);
        v(OPR, FADD, 0, 0, c(0,0,2'b00,0,0,0,0,3'd0,1,1,0,0), 0);
        // lw with two MEM wait cycles
        v(OLW, 6'd0, 0, 1, F1, 1);
        v(OLW, 6'd0, 0, 1, Z, 1);
        v(OLW, 6'd0, 0, 1, c(0,0,2'b00,0,0,0,1,3'd0,0,0,0,0), 1);
        v(OLW, 6'd0, 0, 0, c(0,0,2'b00,1,0,1,0,3'd0,0,0,0,0), 1);
        v(OLW, 6'd0, 0, 0, c(0,0,2'b00,1,0,1,0,3'd0,0,0,0,0), 1);
        v(OLW, 6'd0, 0, 1, c(0,0,2'b00,1,0,1,0,3'd0,0,0,0,0), 1);
        v(OLW, 6'd0, 0, 0, c(0,0,2'b00,0,0,0,0,3'd0,1,0,1,0), 1);
        // beq taken, then not taken
        v(OBEQ, 6'd0, 0, 1, F1, 2);
        v(OBEQ, 6'd0, 0, 1, Z, 2);
        v(OBEQ, 6'd0, 1, 1, c(1,0,2'b01,0,0,0,0,3'd1,0,0,0,0), 2);
        v(OBEQ, 6'd0, 0, 1, F1, 3);
        v(OBEQ, 6'd0, 0, 1, Z, 3);
        v(OBEQ, 6'd0, 0, 1, c(0,0,2'b01,0,0,0,0,3'd1,0,0,0,0), 3);
        // illegal opcode, then illegal R-type func
        v(OBAD, 6'd0, 0, 1, F1, 4);
        v(OBAD, 6'd0, 0, 1, c(0,0,2'b00,0,0,0,0,3'd0,0,0,0,1), 4);
        v(OPR, FBAD, 0, 1, F1, 4);
        v(OPR, FBAD, 0, 1, c(0,0,2'b00,0,0,0,0,3'd0,0,0,0,1), 4);
        // sw with one FETCH wait cycle
        v(OSW, 6'd0, 0, 0, F0, 4);
        v(OSW, 6'd0, 0, 1, F1, 4);
        v(OSW, 6'd0, 0, 1, Z, 4);
        v(OSW, 6'd0, 0, 1, c(0,0,2'b00,0,0,0,1,3'd0,0,0,0,0), 4);
        v(OSW, 6'd0, 0, 1, c(0,0,2'b00,0,1,1,0,3'd0,0,0,0,0), 4);
        // addi / ori with IR fields changing after DECODE: latched copy governs
        v(OADDI, 6'd0, 0, 1, F1, 5);
        v(OADDI, 6'd0, 0, 1, Z, 5);
        v(OBAD, FBAD, 0, 1, c(0,0,2'b00,0,0,0,1,3'd0,0,0,0,0), 5);
        v(OBAD, FBAD, 0, 1, c(0,0,2'b00,0,0,0,0,3'd0,1,0,0,0), 5);
        v(OORI, 6'd0, 0, 1, F1, 6);
        v(OORI, 6'd0, 0, 1, Z, 6);
        v(OPR, FSUB, 0, 1, c(0,0,2'b00,0,0,0,1,3'd3,0,0,0,0), 6);
        v(OPR, FSUB, 0, 1, c(0,0,2'b00,0,0,0,0,3'd0,1,0,0,0), 6);
        // remaining R-type functions
        v(OPR, FSUB, 0, 1, F1, 7);
        v(OPR, FSUB, 0, 1, Z, 7);
        v(OPR, FSUB, 0, 1, c(0,0,2'b00,0,0,0,0,3'd1,0,0,0,0), 7);
        v(OPR, FSUB, 0, 1, c(0,0,2'b00,0,0,0,0,3'd0,1,1,0,0), 7);
        v(OPR, FAND, 0, 1, F1, 8);
        v(OPR, FAND, 0, 1, Z, 8);
        v(OPR, FAND, 0, 1, c(0,0,2'b00,0,0,0,0,3'd2,0,0,0,0), 8);
        v(OPR, FAND, 0, 1, c(0,0,2'b00,0,0,0,0,3'd0,1,1,0,0), 8);
        v(OPR, FOR, 0, 1, F1, 9);
        v(OPR, FOR, 0, 1, Z, 9);
        v(OPR, FOR, 0, 1, c(0,0,2'b00,0,0,0,0,3'd3,0,0,0,0), 9);
        v(OPR, FOR, 0, 1, c(0,0,2'b00,0,0,0,0,3'd0,1,1,0,0), 9);
        v(OPR, FSLT, 0, 1, F1, 10);
        v(OPR, FSLT, 0, 1, Z, 10);
        v(OPR, FSLT, 0, 1, c(0,0,2'b00,0,0,0,0,3'd4,0,0,0,0), 10);
        v(OPR, FSLT, 0, 1, c(0,0,2'b00,0,0,0,0,3'd0,1,1,0,0), 10);
        // jump, then a stalled FETCH to observe the final count
        v(OJ, 6'd0, 0, 1, F1, 11);
        v(OJ, 6'd0, 0, 1, c(1,0,2'b10,0,0,0,0,3'd0,0,0,0,0), 11);
        v(OPR, 6'd0, 0, 0, F0, 12);

        rst_n = 1'b0;
        bus.op = '0; bus.func = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_ctl("reset_ctl", Z);
        chk_ret("reset_ret", bus.retired, 0);
        chk_ret("reset_ret4", {28'd0, bus4.retired}, 0);
        rst_n = 1'b1;
        #1;
        chk_ctl("s_rst_ctl", Z);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].op, tbl[i].func, tbl[i].zero, tbl[i].rdy);
            chk_ctl($sformatf("vec%0d", i), tbl[i].ctl);
            chk_ret($sformatf("vec%0d", i), bus.retired, tbl[i].ret);
        end

        // Async reset while sw is in MEM with memwrite high
        cyc(OSW, 6'd0, 0, 1); chk_ctl("sw_fetch", F1);
        cyc(OSW, 6'd0, 0, 1);
        cyc(OSW, 6'd0, 0, 1);
        cyc(OSW, 6'd0, 0, 0); chk_ctl("sw_mem_wait", c(0,0,2'b00,0,1,1,0,3'd0,0,0,0,0));
        #2;
        rst_n = 1'b0;
        #1;
        chk_ctl("async_rst_ctl", Z);
        chk_ret("async_rst_ret", bus.retired, 0);
        chk_ret("async_rst_ret4", {28'd0, bus4.retired}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        chk_ctl("post_rst_s_rst", Z);

        // 16 jumps: the 4-bit counter wraps 15 -> 0
        for (int i = 0; i < 16; i++) begin
            cyc(OJ, 6'd0, 0, 1);
            chk_ctl($sformatf("wrap_fetch%0d", i), F1);
            chk_ret($sformatf("wrap_ret4_%0d", i), {28'd0, bus4.retired}, 32'(i));
            cyc(OJ, 6'd0, 0, 1);
            chk_ctl($sformatf("wrap_j%0d", i), c(1,0,2'b10,0,0,0,0,3'd0,0,0,0,0));
        end
        cyc(OJ, 6'd0, 0, 0);
        chk_ret("wrap_ret4_final", {28'd0, bus4.retired}, 0);
        chk_ret("wrap_ret32_final", bus.retired, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
